instr_mem_responder: RTL

- Responder side of the instruction fetch interface: accepts word addresses from the fetch stage and returns instructions one cycle later from on-chip storage.
- Contains a byte-serial program loader that fills the memory after reset or on request.
- Drives a ready signal that the fetch stage uses as its stall source while loading is in progress.

---
 rtl/instr_mem_responder_pkg.sv | 26 ++
 rtl/instr_mem_responder_if.sv | 34 +++
 rtl/instr_mem_responder_load_word_assembler.sv | 49 ++++
 rtl/instr_mem_responder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/instr_mem_responder_pkg.sv
// Shared types and helpers for the instruction memory responder.
// Holds the controller state encoding, the default NOP word and the
// fetch-address range check used by the response path.
package instr_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;

  // RISC-V "addi x0, x0, 0": harmless filler for faulted fetches.
  localparam logic [WORD_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True when a byte address falls inside a memory of 'depth' 32-bit words.
  // Compared at 34 bits so 4*depth cannot wrap for large depths.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned depth);
    logic [ADDR_W+1:0] limit;
    limit = (ADDR_W + 2)'(depth) << 2;
    return ({2'b00, addr} < limit);
  endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// Instruction fetch bus between the fetch stage (master) and the
// instruction memory responder (slave).
interface instr_mem_responder_if;
  import instr_mem_pkg::*;

  logic              FetchReq;
  logic [ADDR_W-1:0] FetchAddr;
  logic              FetchReady;
  logic              InstrValid;
  logic [WORD_W-1:0] InstrOut;
  logic              Fault;
  logic [ADDR_W-1:0] FaultAddr;

  modport master (
    output FetchReq,
    output FetchAddr,
    input  FetchReady,
    input  InstrValid,
    input  InstrOut,
    input  Fault,
    input  FaultAddr
  );

  modport slave (
    input  FetchReq,
    input  FetchAddr,
    output FetchReady,
    output InstrValid,
    output InstrOut,
    output Fault,
    output FaultAddr
  );

endinterface

// File: rtl/instr_mem_responder_load_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
// The completed word is presented combinationally in the cycle its final
// byte arrives, so the owner can write it on that same clock edge. Lanes
// above the current byte are forced to zero, which gives the zero-filled
// partial word required when the stream ends early.
module load_word_assembler
  import instr_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  input  logic              load_valid, // already qualified by LOAD state
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  input  logic              clear,      // restart from lane 0
  output logic [WORD_W-1:0] word,
  output logic              word_wr,
  output logic              last_seen
);

  logic [1:0]      byte_cnt_reg;
  logic [3:0][7:0] held_reg;

  // A word is complete on its 4th byte or when the stream ends.
  assign word_wr   = load_valid & ((byte_cnt_reg == 2'd3) | load_last);
  assign last_seen = load_valid & load_last;

  // Lane select: bytes already held, the byte arriving now, or zero fill.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign word[gi*8 +: 8] = (2'(gi) < byte_cnt_reg)  ? held_reg[gi] :
                               (2'(gi) == byte_cnt_reg) ? load_byte    :
                                                          8'h00;
    end
  endgenerate

  // Byte counter and lane storage; reset or clear discards a partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_reg <= 2'd0;
      held_reg     <= '0;
    end else if (clear) begin
      byte_cnt_reg <= 2'd0;
    end else if (load_valid) begin
      held_reg[byte_cnt_reg] <= load_byte;
      byte_cnt_reg           <= word_wr ? 2'd0 : byte_cnt_reg + 2'd1;
    end
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory responder.
// LOAD: a byte-serial loader fills the word array; fetches are stalled.
// RUN:  accepted fetches return a word one cycle later; misaligned or
//       out-of-range addresses return the NOP word and flag Fault.
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int                DEPTH_WORDS   = 256,
  parameter bit                LOAD_ON_RESET = 1'b1,
  parameter logic [WORD_W-1:0] NOP_WORD      = NOP_WORD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,          // asynchronous, active-low
  instr_mem_responder_if.slave  fetch,
  input  logic                  LoadStart,
  input  logic                  LoadValid,
  input  logic [7:0]            LoadByte,
  input  logic                  LoadLast,
  output logic                  LoadOverflow,
  output logic                  Loading
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // word_cnt carries one extra bit so reaching DEPTH_WORDS is visible
  // instead of silently wrapping onto word 0.
  localparam logic [IDX_W:0] WORD_LIMIT = (IDX_W + 1)'(DEPTH_WORDS);

  // Controller state
  state_t         state_reg;
  logic [IDX_W:0] word_cnt_reg;
  logic           overflow_reg;

  // Response path state
  logic              instr_valid_reg;
  logic              fault_reg;
  logic [ADDR_W-1:0] fault_addr_reg;
  logic              nop_sel_reg;   // response is the NOP word, not RAM data
  logic [WORD_W-1:0] rd_data_reg;

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Loader signals
  logic              in_load;
  logic              in_run;
  logic              restart;
  logic              asm_valid;
  logic [WORD_W-1:0] asm_word;
  logic              asm_word_wr;
  logic              asm_last;
  logic              at_limit;
  logic              mem_we;
  logic [IDX_W-1:0]  wr_idx;

  // Fetch signals
  logic              fetch_ready;
  logic              accept;
  logic              fetch_bad;
  logic              mem_rd_en;
  logic [IDX_W-1:0]  rd_idx;

  assign in_load   = (state_reg == LOAD);
  assign in_run    = (state_reg == RUN);
  assign restart   = in_run & LoadStart;
  assign asm_valid = in_load & LoadValid;   // bytes outside LOAD are dropped

  load_word_assembler u_assembler (
    .clk        (clk),
    .rst        (rst),
    .load_valid (asm_valid),
    .load_byte  (LoadByte),
    .load_last  (LoadLast),
    .clear      (restart),
    .word       (asm_word),
    .word_wr    (asm_word_wr),
    .last_seen  (asm_last)
  );

  assign at_limit = (word_cnt_reg == WORD_LIMIT);
  assign mem_we   = asm_word_wr & ~at_limit;
  assign wr_idx   = word_cnt_reg[IDX_W-1:0];

  // LoadStart steals the cycle: the same-cycle request is refused.
  assign fetch_ready = in_run & ~LoadStart;
  assign accept      = fetch.FetchReq & fetch_ready;
  assign fetch_bad   = (fetch.FetchAddr[1:0] != 2'b00) |
                       ~addr_in_range(fetch.FetchAddr, DEPTH_WORDS);
  assign mem_rd_en   = accept & ~fetch_bad;
  assign rd_idx      = fetch.FetchAddr[IDX_W+1:2];

  // LOAD/RUN controller with word counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= LOAD_ON_RESET ? LOAD : RUN;
      word_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (asm_word_wr) begin
            if (at_limit) begin
              // Array full: drop the word and hand control to the fetch side.
              overflow_reg <= 1'b1;
              state_reg    <= RUN;
            end else begin
              word_cnt_reg <= word_cnt_reg + 1'b1;
              if (asm_last) begin
                state_reg <= RUN;
              end
            end
          end
        end
        RUN: begin
          if (LoadStart) begin
            state_reg    <= LOAD;
            word_cnt_reg <= '0;
            overflow_reg <= 1'b0;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  // Response flags: valid/fault last one cycle, the NOP select and the
  // faulting address persist until the next accepted request / fault.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_valid_reg <= 1'b0;
      fault_reg       <= 1'b0;
      fault_addr_reg  <= '0;
      nop_sel_reg     <= 1'b1;
    end else begin
      instr_valid_reg <= accept;
      fault_reg       <= accept & fetch_bad;
      if (accept) begin
        nop_sel_reg <= fetch_bad;
      end
      if (accept & fetch_bad) begin
        fault_addr_reg <= fetch.FetchAddr;
      end
    end
  end

  // Word array: loader write port and registered fetch read port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= asm_word;
    end
    if (mem_rd_en) begin
      rd_data_reg <= mem[rd_idx];
    end
  end

  assign fetch.FetchReady = fetch_ready;
  assign fetch.InstrValid = instr_valid_reg;
  assign fetch.InstrOut   = nop_sel_reg ? NOP_WORD : rd_data_reg;
  assign fetch.Fault      = fault_reg;
  assign fetch.FaultAddr  = fault_addr_reg;
  assign LoadOverflow     = overflow_reg;
  assign Loading          = in_load;

endmodule
